led_matrix_scan_scroller: RTL



---
 rtl/led_matrix_scan_scroller.sv | 110 +++++++++++
 1 files changed

// File: rtl/led_matrix_scan_scroller.sv
// Column-multiplexed LED matrix driver: DEPTH-column bitmap buffer, WINDOW-column scan,
// per-slot brightness PWM and frame-synchronous wrap-around horizontal scrolling.
module led_matrix_scan_scroller #(
   parameter int ROWS          = 4,
   parameter int WINDOW        = 4,
   parameter int DEPTH         = 16,
   parameter int SCAN_DIV      = 1000,
   parameter int SCROLL_FRAMES = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [ROWS-1:0]          wr_data,
   input  logic                     scroll_en,
   input  logic                     scroll_dir,
   input  logic [3:0]               brightness,
   output logic [WINDOW-1:0]        col_sel,
   output logic [ROWS-1:0]          row_out,
   output logic                     frame_tick
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int SW = $clog2(SCAN_DIV);
   localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
   localparam int TW = SW + 5;

   logic [SW-1:0]   slot_cnt;
   logic [CW-1:0]   col_idx;
   logic [AW-1:0]   offset;
   logic [FW-1:0]   frame_cnt;
   logic [ROWS-1:0] col_data;
   logic [3:0]      bright_q;
   logic [ROWS-1:0] buffer [DEPTH];

   logic            slot_start;
   logic            slot_last;
   logic            col_last;
   logic            frame_wrap;
   logic            lit;
   logic [AW-1:0]   rd_idx;
   logic [ROWS-1:0] cur_data;
   logic [3:0]      cur_bright;
   logic [TW-1:0]   thr;

   // NOTE: every signal is assigned on every pass through this block, so no latch can be inferred.
   always_comb begin
      slot_start = (slot_cnt == '0);
      slot_last  = (slot_cnt == SW'(SCAN_DIV - 1));
      col_last   = (col_idx == CW'(WINDOW - 1));
      frame_wrap = slot_last && col_last;
      rd_idx     = offset + AW'(col_idx);
      // The slot-start cycle uses the fresh read so the first lit cycle already shows the new column.
      cur_data   = slot_start ? buffer[rd_idx] : col_data;
      cur_bright = slot_start ? brightness : bright_q;
      thr        = ((TW'(cur_bright) + TW'(1)) * TW'(SCAN_DIV)) >> 4;
      lit        = (TW'(slot_cnt) < thr);
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt   <= '0;
         col_idx    <= '0;
         offset     <= '0;
         frame_cnt  <= '0;
         col_data   <= '0;
         bright_q   <= '0;
         col_sel    <= '0;
         row_out    <= '0;
         frame_tick <= 1'b0;
      end else begin
         slot_cnt <= slot_last ? '0 : slot_cnt + SW'(1);
         if (slot_last) begin
            col_idx <= col_last ? '0 : col_idx + CW'(1);
         end
         if (slot_start) begin
            col_data <= cur_data;
            bright_q <= cur_bright;
         end
         col_sel    <= lit ? (WINDOW'(1) << col_idx) : '0;
         row_out    <= lit ? cur_data : '0;
         frame_tick <= frame_wrap;
         // Offset moves only together with col_idx returning to 0, so a frame never mixes offsets.
         if (frame_wrap) begin
            if (!scroll_en) begin
               frame_cnt <= '0;
            end else if (frame_cnt == FW'(SCROLL_FRAMES - 1)) begin
               frame_cnt <= '0;
               offset    <= scroll_dir ? offset - AW'(1) : offset + AW'(1);
            end else begin
               frame_cnt <= frame_cnt + FW'(1);
            end
         end
      end
   end

   // NOTE: the buffer is held in flops with an explicit reset so a reset always blanks stale bitmap content.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            buffer[i] <= '0;
         end
      end else if (wr_en) begin
         buffer[wr_addr] <= wr_data;
      end
   end

endmodule
